pixel_frame_ctrl: RTL and testbench
===================================

// Module: pixel_frame_ctrl
// PURPOSE
//  Frame sequencer for the RGB pixel-count datapath. Accepts a pixel stream with a valid/ready handshake and
//  classifies each pixel by its dominant channel. Pulses exactly one of Radd_en/Gadd_en/Badd_en per counted pixel.
//  Clears the datapath counters at frame start. After the last pixel, waits for the compare logic to settle,
//  then latches and presents the dominant colour and its pixel count on a result handshake.
// PARAMETERS
//  FRAME_PIXELS  16384  pixels per frame; legal range 1..32767 (15-bit counts)
//  SETTLE_CYC    1      cycles waited after the final count update before sampling the compare outputs (>=1)
//  THRESH        64     8-bit minimum dominant-channel value for a pixel to be counted (used only with PIXEL_THRESH_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  start        in   1   begin a frame; sampled only in IDLE
//  pix_valid    in   1   pixel present
//  pix_ready    out  1   high only in ACCUM
//  pix_r/g/b    in   8   pixel channel values
//  Radd_en      out  1   one-cycle increment pulse to the R counter (G/B: Gadd_en, Badd_en)
//  Gadd_en      out  1
//  Badd_en      out  1
//  cnt_clr      out  1   active-high one-cycle clear of the datapath counters
//  Rd_en        in   1   compare result: R dominant (Gd_en, Bd_en likewise; one-hot)
//  Gd_en        in   1
//  Bd_en        in   1
//  Rpixel_num   in   15  datapath counts (Gpixel_num, Bpixel_num likewise)
//  Gpixel_num   in   15
//  Bpixel_num   in   15
//  res_valid    out  1   result available; held until accepted
//  res_ready    in   1   result consumer ready
//  res_color    out  2   00=R 01=G 10=B 11=error (Rd/Gd/Bd not one-hot)
//  res_count    out  15  count of the dominant colour
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including res_*, cnt_clr and the add_en pulses; pix_cnt=0. Reset takes effect
//    immediately, mid-frame included. The next start performs a full clear.
//  - IDLE: on start=1, go to CLEAR. start is ignored in all other states.
//  - CLEAR: cnt_clr=1 for exactly 1 cycle; pix_cnt<=0; go to ACCUM.
//  - ACCUM: pix_ready=1. A handshake is pix_valid&&pix_ready at a rising edge.
//    - On each handshake, pix_cnt increments and the classification is registered.
//    - The selected add_en is high for the single following cycle. At most one add_en is ever high.
//    - Classification: R if r>=g && r>=b; else G if g>=b; else B (ties resolve R>G>B).
//    - Handshake with pix_cnt==FRAME_PIXELS-1 goes to DRAIN; pix_ready drops in the next cycle.
//    - Gaps in pix_valid produce no pulses and no count change.
//  - DRAIN: 1 cycle; the last add_en pulse is active and the datapath counter updates at its end; go to SETTLE.
//  - SETTLE: wait SETTLE_CYC cycles.
//    - On exit, latch res_color from Rd/Gd/Bd_en and res_count from the matching count (0 on error).
//    - Set res_valid=1 and go to DONE.
//  - DONE: res_valid, res_color and res_count are held stable. On res_valid&&res_ready: res_valid<=0, go to IDLE.
//    res_color/res_count keep their last value.
//  - Latency: last pixel handshake edge to res_valid rising = 2+SETTLE_CYC cycles.
//  - cnt_clr is never asserted in the same cycle as any add_en.
// CONFIGURATION
//  - PIXEL_THRESH_EN defined: a pixel whose dominant channel value is < THRESH is still accepted and advances
//    pix_cnt, but produces no add_en. An all-dim frame yields counts 0/0/0 and res_color per the compare (R on ties).
//  - PIXEL_THRESH_EN undefined: THRESH is unused; every accepted pixel pulses exactly one add_en, so the sum of
//    pulses equals FRAME_PIXELS.
// STRUCTURE
//  - Shared header pixel_defs.vh: colour codes COL_R=2'b00, COL_G=2'b01, COL_B=2'b10, COL_ERR=2'b11; state
//    encodings for IDLE/CLEAR/ACCUM/DRAIN/SETTLE/DONE; count width 15.
//  - One sub-module: dominant_color (combinational 3x8-bit max and tie-break, one-hot output plus max value for the
//    threshold test).
//  - The FSM, pix_cnt, settle counter and result registers live in pixel_frame_ctrl.
// TESTING
//  1 FRAME_PIXELS=4; pixels (200,10,10) x3 then (10,200,10) -> 3 Radd_en pulses, 1 Gadd_en pulse; res_color=00,
//    res_count=3.
//  2 Ties: (100,100,50) -> Radd_en; (50,100,100) -> Gadd_en; (0,0,0) -> Radd_en.
//  3 Backpressure: res_ready=0 for 10 cycles -> res_valid/res_color/res_count stable; pix_ready=0; start ignored;
//    res_ready=1 -> IDLE the next cycle.
//  4 Reset mid-frame after 2 pixels: outputs 0 immediately. Then start -> cnt_clr pulse, and a fresh frame of 4
//    pixels counts from 0.
//  5 Pixel (30,20,10): PIXEL_THRESH_EN with THRESH=64 -> no add_en but the frame still ends after 4 pixels;
//    without the macro -> Radd_en.
//  6 pix_valid toggling every other cycle, FRAME_PIXELS=8 -> exactly 8 add_en pulses; res_valid 3 cycles after the
//    8th handshake (SETTLE_CYC=1).

Source files
------------

// File: rtl/pixel_frame_ctrl_pkg.sv
// Shared types for the pixel frame sequencer: FSM states, colour codes, count width.
package pixel_frame_ctrl_pkg;

  localparam int unsigned CntW = 15;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StDrain,
    StSettle,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ColR   = 2'b00,
    ColG   = 2'b01,
    ColB   = 2'b10,
    ColErr = 2'b11
  } color_e;

  // dom is {b, g, r}; anything other than exactly one bit set is an error.
  function automatic color_e decode_color(input logic [2:0] dom);
    case (dom)
      3'b001:  return ColR;
      3'b010:  return ColG;
      3'b100:  return ColB;
      default: return ColErr;
    endcase
  endfunction

endpackage

// File: rtl/pixel_frame_ctrl_dominant_color.sv
// Combinational dominant-channel picker: one-hot {b,g,r} with ties resolved R > G > B,
// plus the winning channel value for the brightness threshold.
module pixel_frame_ctrl_dominant_color (
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [2:0] onehot_o,
  output logic [7:0] max_o
);

  always_comb begin
    onehot_o = 3'b000;
    max_o    = 8'd0;
    if (r_i >= g_i && r_i >= b_i) begin
      onehot_o = 3'b001;
      max_o    = r_i;
    end else if (g_i >= b_i) begin
      onehot_o = 3'b010;
      max_o    = g_i;
    end else begin
      onehot_o = 3'b100;
      max_o    = b_i;
    end
  end

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the RGB pixel-count datapath: clear, accumulate, settle, report.
// Optional feature: define PIXEL_THRESH_EN to suppress add pulses for pixels dimmer than Thresh.
module pixel_frame_ctrl
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int unsigned FramePixels = 16384,
  parameter int unsigned SettleCyc   = 1,
  parameter int unsigned Thresh      = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  input  logic [7:0]      pix_r_i,
  input  logic [7:0]      pix_g_i,
  input  logic [7:0]      pix_b_i,
  output logic            radd_en_o,
  output logic            gadd_en_o,
  output logic            badd_en_o,
  output logic            cnt_clr_o,
  input  logic            rd_en_i,
  input  logic            gd_en_i,
  input  logic            bd_en_i,
  input  logic [CntW-1:0] rpixel_num_i,
  input  logic [CntW-1:0] gpixel_num_i,
  input  logic [CntW-1:0] bpixel_num_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [1:0]      res_color_o,
  output logic [CntW-1:0] res_count_o,
  output logic            busy_o
);

  localparam int unsigned SetW = (SettleCyc < 1) ? 1 : $clog2(SettleCyc + 1);
  localparam logic [CntW-1:0] LastPix = CntW'(FramePixels - 1);
  localparam logic [SetW-1:0] SettleInit = SetW'(SettleCyc);
  localparam logic [7:0] ThreshV = 8'(Thresh);

  state_e            state_q;
  logic [CntW-1:0]   pix_cnt_q;
  logic [SetW-1:0]   settle_q;
  logic [2:0]        add_en_q;
  logic              res_valid_q;
  color_e            res_color_q;
  logic [CntW-1:0]   res_count_q;

  logic [2:0]        dom_onehot;
  logic [7:0]        dom_max;
  logic              pix_pass;
  color_e            cmp_color;
  logic [CntW-1:0]   cmp_count;

  pixel_frame_ctrl_dominant_color u_dominant_color (
    .r_i      (pix_r_i),
    .g_i      (pix_g_i),
    .b_i      (pix_b_i),
    .onehot_o (dom_onehot),
    .max_o    (dom_max)
  );

`ifdef PIXEL_THRESH_EN
  assign pix_pass = (dom_max >= ThreshV);
`else
  logic unused_thresh;
  assign unused_thresh = ^{dom_max, ThreshV};
  assign pix_pass = 1'b1;
`endif

  always_comb begin
    cmp_color = decode_color({bd_en_i, gd_en_i, rd_en_i});
    cmp_count = '0;
    case (cmp_color)
      ColR:    cmp_count = rpixel_num_i;
      ColG:    cmp_count = gpixel_num_i;
      ColB:    cmp_count = bpixel_num_i;
      default: cmp_count = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      settle_q    <= '0;
      add_en_q    <= '0;
      res_valid_q <= 1'b0;
      res_color_q <= ColR;
      res_count_q <= '0;
    end else begin
      add_en_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (start_i) state_q <= StClear;
        end
        StClear: begin
          pix_cnt_q <= '0;
          state_q   <= StAccum;
        end
        StAccum: begin
          if (pix_valid_i) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            add_en_q  <= pix_pass ? dom_onehot : 3'b000;
            if (pix_cnt_q == LastPix) state_q <= StDrain;
          end
        end
        StDrain: begin
          settle_q <= SettleInit;
          state_q  <= StSettle;
        end
        // Counts down to zero and samples one cycle later, so the compare has a full
        // SettleCyc cycles of slack beyond the counter update.
        StSettle: begin
          if (settle_q == '0) begin
            res_color_q <= cmp_color;
            res_count_q <= cmp_count;
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StDone: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_ready_o = (state_q == StAccum);
  assign cnt_clr_o   = (state_q == StClear);
  assign busy_o      = (state_q != StIdle);
  assign radd_en_o   = add_en_q[0];
  assign gadd_en_o   = add_en_q[1];
  assign badd_en_o   = add_en_q[2];
  assign res_valid_o = res_valid_q;
  assign res_color_o = res_color_q;
  assign res_count_o = res_count_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl: a 4-pixel instance with a behavioural counter/compare
// datapath, and an 8-pixel instance for gapped-stream pulse counting and result latency.
module tb_pixel_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, res_ready;
  logic [7:0] pix_r, pix_g, pix_b;
  logic start4, valid4, start8, valid8;
  logic cmp_ovr;

  logic ready4, radd4, gadd4, badd4, clr4, rv4, busy4;
  logic [1:0] col4;
  logic [14:0] cnt4;
  logic ready8, radd8, gadd8, badd8, clr8, rv8, busy8;
  logic [1:0] col8;
  logic [14:0] cnt8;

  // Behavioural datapath for the 4-pixel instance.
  logic [14:0] cr, cg, cb;
  logic rd, gd, bd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr <= '0; cg <= '0; cb <= '0;
    end else if (clr4) begin
      cr <= '0; cg <= '0; cb <= '0;
    end else begin
      if (radd4) cr <= cr + 15'd1;
      if (gadd4) cg <= cg + 15'd1;
      if (badd4) cb <= cb + 15'd1;
    end
  end

  always_comb begin
    rd = (cr >= cg) && (cr >= cb);
    gd = !rd && (cg >= cb);
    bd = !rd && !gd;
    if (cmp_ovr) begin
      rd = 1'b1; gd = 1'b1; bd = 1'b0;
    end
  end

  int n8 = 0;
  int bad_cycles = 0;
  always @(posedge clk) begin
    n8 <= n8 + $countones({radd8, gadd8, badd8});
    if ($countones({radd4, gadd4, badd4}) > 1 || (clr4 && (radd4 | gadd4 | badd4)) ||
        $countones({radd8, gadd8, badd8}) > 1 || (clr8 && (radd8 | gadd8 | badd8)))
      bad_cycles <= bad_cycles + 1;
  end

  pixel_frame_ctrl #(.FramePixels(4), .SettleCyc(1), .Thresh(64)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .pix_valid_i(valid4), .pix_ready_o(ready4),
    .pix_r_i(pix_r), .pix_g_i(pix_g), .pix_b_i(pix_b),
    .radd_en_o(radd4), .gadd_en_o(gadd4), .badd_en_o(badd4), .cnt_clr_o(clr4),
    .rd_en_i(rd), .gd_en_i(gd), .bd_en_i(bd),
    .rpixel_num_i(cr), .gpixel_num_i(cg), .bpixel_num_i(cb),
    .res_valid_o(rv4), .res_ready_i(res_ready), .res_color_o(col4), .res_count_o(cnt4),
    .busy_o(busy4)
  );

  pixel_frame_ctrl #(.FramePixels(8), .SettleCyc(1), .Thresh(64)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .pix_valid_i(valid8), .pix_ready_o(ready8),
    .pix_r_i(pix_r), .pix_g_i(pix_g), .pix_b_i(pix_b),
    .radd_en_o(radd8), .gadd_en_o(gadd8), .badd_en_o(badd8), .cnt_clr_o(clr8),
    .rd_en_i(rd), .gd_en_i(gd), .bd_en_i(bd),
    .rpixel_num_i(cr), .gpixel_num_i(cg), .bpixel_num_i(cb),
    .res_valid_o(rv8), .res_ready_i(res_ready), .res_color_o(col8), .res_count_o(cnt8),
    .busy_o(busy8)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px4(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_r = r; pix_g = g; pix_b = b;
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
  endtask

  task automatic start_frame4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("clear_pulse", {31'd0, clr4}, 1);
    tick();
    check("clear_one_cycle", {31'd0, clr4}, 0);
    check("accum_ready", {31'd0, ready4}, 1);
  endtask

  logic [14:0] exp_cnt2;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; res_ready = 1'b0; cmp_ovr = 1'b0;
    start4 = 1'b0; valid4 = 1'b0; start8 = 1'b0; valid8 = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    tick(); tick();
    check("rst_ready", {31'd0, ready4}, 0);
    check("rst_busy", {31'd0, busy4}, 0);
    check("rst_res_valid", {31'd0, rv4}, 0);
    check("rst_res_color", {30'd0, col4}, 0);
    check("rst_res_count", {17'd0, cnt4}, 0);
    check("rst_adds", {29'd0, radd4, gadd4, badd4}, 0);
    check("rst_clr", {31'd0, clr4}, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: three red, one green.
    start_frame4();
    px4(8'd200, 8'd10, 8'd10);
    check("t1_radd", {29'd0, badd4, gadd4, radd4}, 3'b001);
    px4(8'd200, 8'd10, 8'd10);
    px4(8'd200, 8'd10, 8'd10);
    check("t1_ready_mid", {31'd0, ready4}, 1);
    px4(8'd10, 8'd200, 8'd10);
    check("t1_gadd", {29'd0, badd4, gadd4, radd4}, 3'b010);
    check("t1_drain_ready", {31'd0, ready4}, 0);
    tick();
    check("t1_no_res_e1", {31'd0, rv4}, 0);
    tick();
    check("t1_no_res_e2", {31'd0, rv4}, 0);
    tick();
    check("t1_res_valid", {31'd0, rv4}, 1);
    check("t1_res_color", {30'd0, col4}, 0);
    check("t1_res_count", {17'd0, cnt4}, 3);

    // Test 3: result backpressure; start is ignored while holding.
    start4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, rv4}, 1);
      check("t3_hold_count", {17'd0, cnt4}, 3);
      check("t3_hold_color", {30'd0, col4}, 0);
      check("t3_hold_ready", {31'd0, ready4}, 0);
    end
    start4 = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t3_idle_busy", {31'd0, busy4}, 0);
    check("t3_idle_valid", {31'd0, rv4}, 0);
    check("t3_keep_count", {17'd0, cnt4}, 3);

    // Tests 2 and 5: tie-breaks and a dim pixel.
    start_frame4();
    px4(8'd100, 8'd100, 8'd50);
    check("t2_tie_rg", {29'd0, badd4, gadd4, radd4}, 3'b001);
    px4(8'd50, 8'd100, 8'd100);
    check("t2_tie_gb", {29'd0, badd4, gadd4, radd4}, 3'b010);
    px4(8'd0, 8'd0, 8'd0);
`ifdef PIXEL_THRESH_EN
    check("t2_tie_zero", {29'd0, badd4, gadd4, radd4}, 3'b000);
`else
    check("t2_tie_zero", {29'd0, badd4, gadd4, radd4}, 3'b001);
`endif
    px4(8'd30, 8'd20, 8'd10);
`ifdef PIXEL_THRESH_EN
    check("t5_dim", {29'd0, badd4, gadd4, radd4}, 3'b000);
    exp_cnt2 = 15'd1;
`else
    check("t5_dim", {29'd0, badd4, gadd4, radd4}, 3'b001);
    exp_cnt2 = 15'd3;
`endif
    check("t5_frame_end", {31'd0, ready4}, 0);
    tick(); tick(); tick();
    check("t2_res_valid", {31'd0, rv4}, 1);
    check("t2_res_color", {30'd0, col4}, 0);
    check("t2_res_count", {17'd0, cnt4}, {17'd0, exp_cnt2});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Test 4: reset mid-frame, then a fresh frame counts from zero.
    start_frame4();
    px4(8'd200, 8'd10, 8'd10);
    px4(8'd200, 8'd10, 8'd10);
    rst_n = 1'b0;
    #1;
    check("t4_rst_adds", {29'd0, badd4, gadd4, radd4}, 0);
    check("t4_rst_ready", {31'd0, ready4}, 0);
    check("t4_rst_busy", {31'd0, busy4}, 0);
    check("t4_rst_count", {17'd0, cnt4}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_frame4();
    px4(8'd10, 8'd10, 8'd200);
    check("t4_badd", {29'd0, badd4, gadd4, radd4}, 3'b100);
    px4(8'd10, 8'd10, 8'd200);
    px4(8'd10, 8'd10, 8'd200);
    check("t4_not_early", {31'd0, ready4}, 1);
    px4(8'd10, 8'd10, 8'd200);
    check("t4_end", {31'd0, ready4}, 0);
    tick(); tick(); tick();
    check("t4_res_color", {30'd0, col4}, 2);
    check("t4_res_count", {17'd0, cnt4}, 4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Non-one-hot compare result reports the error colour with a zero count.
    start_frame4();
    cmp_ovr = 1'b1;
    for (int i = 0; i < 4; i++) px4(8'd10, 8'd200, 8'd10);
    tick(); tick(); tick();
    check("err_res_valid", {31'd0, rv4}, 1);
    check("err_res_color", {30'd0, col4}, 3);
    check("err_res_count", {17'd0, cnt4}, 0);
    cmp_ovr = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Test 6: gapped stream into the 8-pixel instance.
    pix_r = 8'd200; pix_g = 8'd10; pix_b = 8'd10;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t6_clear", {31'd0, clr8}, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      valid8 = 1'b1;
      tick();
      valid8 = 1'b0;
      if (i < 7) tick();
    end
    check("t6_end_ready", {31'd0, ready8}, 0);
    tick();
    check("t6_lat_e1", {31'd0, rv8}, 0);
    tick();
    check("t6_lat_e2", {31'd0, rv8}, 0);
    tick();
    check("t6_lat_e3", {31'd0, rv8}, 1);
    check("t6_pulses", n8, 8);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t6_idle", {31'd0, busy8}, 0);
    check("onehot_and_clr_excl", bad_cycles, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
